// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - size encodings used on req_size
//   - FSM state encoding (also exported on the debug port of the top)
//   - the latched request record
//   - misalignment helper used at accept time
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

    // Only the low 16 bits of store data are kept: full-word stores take
    // req_wdata straight into write_data at accept, sub-word stores need
    // at most a halfword for the merge.
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [15:0] wdata;
    } lsu_req_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational lane logic for the load/store unit (little-endian lanes).
// Ports:
//   word      in  32  word read from memory
//   off       in  2   byte offset within the word (addr[1:0])
//   size      in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   sgn       in  1   sign-extend sub-word loads
//   wdata     in  16  right-aligned store data for sub-word stores
//   load_data out 32  extracted and extended load result
//   merged    out 32  word with the addressed lane(s) replaced by wdata
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        case (off)
            2'd0: byte_lane = word[7:0];
            2'd1: byte_lane = word[15:8];
            2'd2: byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{sgn & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = {{16{sgn & half_lane[15]}}, half_lane};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) merged[31:16] = wdata;
                else        merged[15:0]  = wdata;
            end
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a pipeline and a word-addressed data memory.
// Loads take IDLE->READ->RESP, word stores IDLE->WRITE->RESP, sub-word
// stores do a read-modify-write IDLE->READ->WRITE->RESP, and errored
// requests go IDLE->RESP without touching memory.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake: a request transfers on a rising
//                     edge where both are high; ready is high only in IDLE
//   req_write, req_size, req_signed, req_addr, req_wdata  request fields
//   resp_valid        one-cycle completion pulse, qualified by resp_error
//   resp_rdata        extended load data (0 for stores and errors)
//   mem_address       word index addr[31:2]
//   write_data        store word
//   sig_mem_read      read strobe (registered)
//   sig_mem_write     write strobe (registered)
//   read_data         combinational memory output
//   fsm_state         current FSM state, for observation
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] read_data,
    output lsu_state_e  fsm_state
);

    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    lsu_state_e state_q, state_d;
    lsu_req_t   req_q;
    logic       accept;
    logic       err_now;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign fsm_state = state_q;

    always_comb begin
        err_now = misaligned(req_size, req_addr[1:0])
               || (req_size == SZ_RSVD)
               || ({2'b00, req_addr[31:2]} >= DEPTH_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (err_now)                state_d = ST_RESP;
                    else if (!req_write)        state_d = ST_READ;
                    else if (req_size == SZ_WORD) state_d = ST_WRITE;
                    else                        state_d = ST_READ;
                end
            end
            ST_READ:  state_d = req_q.write ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Lane logic always looks at the live memory output; its results are
    // only used on the edge that ends READ.
    lsu_lane_merge u_lane (
        .word      (read_data),
        .off       (req_q.off),
        .size      (req_q.size),
        .sgn       (req_q.sgn),
        .wdata     (req_q.wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    // Strobes and response flags are registered from the next state so they
    // line up exactly with the state they belong to and cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q         <= '0;
            sig_mem_read  <= 1'b0;
            sig_mem_write <= 1'b0;
            resp_valid    <= 1'b0;
            resp_error    <= 1'b0;
            resp_rdata    <= '0;
            mem_address   <= '0;
            write_data    <= '0;
        end else begin
            sig_mem_read  <= (state_d == ST_READ);
            sig_mem_write <= (state_d == ST_WRITE);
            resp_valid    <= (state_d == ST_RESP);
            // Errors are only ever known at accept and go straight to RESP.
            resp_error    <= accept && err_now;
            resp_rdata    <= '0;
            if (accept) begin
                req_q.write <= req_write;
                req_q.size  <= req_size;
                req_q.sgn   <= req_signed;
                req_q.off   <= req_addr[1:0];
                req_q.wdata <= req_wdata[15:0];
                mem_address <= {2'b00, req_addr[31:2]};
                write_data  <= req_wdata;
            end
            if (state_q == ST_READ) begin
                if (req_q.write) write_data <= merged;
                else             resp_rdata <= load_data;
            end
        end
    end

endmodule
